// File: rtl/alu_dot_product_sequencer.sv
// Dot-product sequencer: drives a shared 8-bit signed ALU with one MULTIPLY
// then one ADD per streamed operand pair and reports the accumulated sum.
module alu_dot_product_sequencer #(
  parameter int LEN_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic [LEN_WIDTH-1:0]         length_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic                         operand_valid_in,
  output logic                         operand_ready_out,
  output logic                         alu_enable_out,
  output logic [2:0]                   alu_opcode_out,
  output logic signed [DATA_WIDTH-1:0] alu_input1_out,
  output logic signed [DATA_WIDTH-1:0] alu_input2_out,
  input  logic signed [DATA_WIDTH-1:0] alu_result_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic signed [DATA_WIDTH-1:0] result_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t                         state_reg;
  logic signed [DATA_WIDTH-1:0]   acc_reg;
  logic signed [DATA_WIDTH-1:0]   prod_reg;
  logic signed [DATA_WIDTH-1:0]   result_reg;
  logic [LEN_WIDTH-1:0]           count_reg;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      prod_reg   <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            acc_reg    <= '0;
            result_reg <= '0;
            if (length_in != '0) begin
              count_reg <= length_in;
              state_reg <= MUL;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        MUL: begin
          // Stall here indefinitely until the producer presents a pair.
          if (operand_valid_in) begin
            prod_reg  <= alu_result_in;
            state_reg <= ACC;
          end
        end
        ACC: begin
          acc_reg   <= alu_result_in;
          count_reg <= count_reg - LEN_WIDTH'(1);
          if (count_reg == LEN_WIDTH'(1)) begin
            // Capture the final sum directly from the ALU so it is valid with done.
            result_reg <= alu_result_in;
            state_reg  <= DONE;
          end else begin
            state_reg <= MUL;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ALU drive must be combinational: the ALU answers in the same cycle.
  always_comb begin
    operand_ready_out = 1'b0;
    alu_enable_out    = 1'b0;
    alu_opcode_out    = OP_ADD;
    alu_input1_out    = '0;
    alu_input2_out    = '0;
    busy_out          = 1'b0;
    done_out          = 1'b0;
    case (state_reg)
      MUL: begin
        busy_out          = 1'b1;
        operand_ready_out = 1'b1;
        if (operand_valid_in) begin
          alu_enable_out = 1'b1;
          alu_opcode_out = OP_MUL;
          alu_input1_out = a_in;
          alu_input2_out = b_in;
        end
      end
      ACC: begin
        busy_out       = 1'b1;
        alu_enable_out = 1'b1;
        alu_opcode_out = OP_ADD;
        alu_input1_out = acc_reg;
        alu_input2_out = prod_reg;
      end
      DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign result_out = result_reg;

endmodule

// File: tb/tb_alu_dot_product_sequencer.sv
// Directed bench for alu_dot_product_sequencer with a behavioural 8-bit ALU
// answering the sequencer's requests in the same cycle.
module tb_alu_dot_product_sequencer;

  logic              clock_in = 1'b0;
  logic              reset_in = 1'b0;
  logic              start_in = 1'b0;
  logic [3:0]        length_in = '0;
  logic signed [7:0] a_in = '0;
  logic signed [7:0] b_in = '0;
  logic              operand_valid_in = 1'b0;
  logic              operand_ready_out;
  logic              alu_enable_out;
  logic [2:0]        alu_opcode_out;
  logic signed [7:0] alu_input1_out;
  logic signed [7:0] alu_input2_out;
  logic signed [7:0] alu_result_in;
  logic              busy_out;
  logic              done_out;
  logic signed [7:0] result_out;

  int errors = 0;
  int checks = 0;

  logic signed [7:0] va [0:3];
  logic signed [7:0] vb [0:3];

  alu_dot_product_sequencer #(.LEN_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .start_in          (start_in),
    .length_in         (length_in),
    .a_in              (a_in),
    .b_in              (b_in),
    .operand_valid_in  (operand_valid_in),
    .operand_ready_out (operand_ready_out),
    .alu_enable_out    (alu_enable_out),
    .alu_opcode_out    (alu_opcode_out),
    .alu_input1_out    (alu_input1_out),
    .alu_input2_out    (alu_input2_out),
    .alu_result_in     (alu_result_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .result_out        (result_out)
  );

  always #5 clock_in = ~clock_in;

  // Shared ALU: wrap-around add and low byte of the signed product.
  logic signed [15:0] full_prod;
  always_comb begin
    full_prod     = alu_input1_out * alu_input2_out;
    alu_result_in = '0;
    if (alu_enable_out) begin
      if (alu_opcode_out == 3'b000)
        alu_result_in = alu_input1_out + alu_input2_out;
      else if (alu_opcode_out == 3'b010)
        alu_result_in = full_prod[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Starts a run of len pairs from va/vb, optionally stalling before pair
  // stall_at and poking start_in on cycle poke_cyc; returns what was observed.
  task automatic run_dot(input int len, input int stall_at, input int stall_n,
                         input int poke_cyc, output int done_cyc,
                         output logic [7:0] res, output logic [23:0] ops,
                         output int enables);
    int idx;
    int stall_left;
    idx        = 0;
    stall_left = stall_n;
    done_cyc   = -1;
    res        = '0;
    ops        = '0;
    enables    = 0;
    @(negedge clock_in);
    start_in  = 1'b1;
    length_in = 4'(len);
    @(posedge clock_in);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock_in);
      start_in  = (cyc == poke_cyc);
      length_in = (cyc == poke_cyc) ? 4'd1 : 4'(len);
      if (idx < len) begin
        a_in = va[idx];
        b_in = vb[idx];
        operand_valid_in = 1'b1;
      end else begin
        operand_valid_in = 1'b0;
      end
      if (idx == stall_at && stall_left > 0 && operand_ready_out) begin
        operand_valid_in = 1'b0;
        stall_left--;
        #1;
        check("stall_alu_enable", 32'(alu_enable_out), 32'd0);
        check("stall_busy", 32'(busy_out), 32'd1);
      end else begin
        #1;
      end
      if (alu_enable_out) begin
        enables++;
        ops = {ops[20:0], alu_opcode_out};
      end
      if (operand_ready_out && operand_valid_in) idx++;
      if (done_out) begin
        done_cyc = cyc;
        res      = $unsigned(result_out);
        break;
      end
    end
    start_in         = 1'b0;
    operand_valid_in = 1'b0;
    // One cycle later the pulse is gone, the block is idle and the result holds.
    @(negedge clock_in);
    #1;
    check("done_one_cycle", 32'(done_out), 32'd0);
    check("idle_after_done", 32'(busy_out), 32'd0);
    check("result_holds", 32'($unsigned(result_out)), 32'(res));
  endtask

  int               dcyc;
  logic [7:0]       res;
  logic [23:0]      ops;
  int               ens;

  initial begin
    reset_in = 1'b1;
    #12;
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_done", 32'(done_out), 32'd0);
    check("reset_ready", 32'(operand_ready_out), 32'd0);
    check("reset_result", 32'($unsigned(result_out)), 32'd0);
    @(negedge clock_in);
    reset_in = 1'b0;

    // Basic: 2*3 + 4*5 + (-1)*6 = 20
    va[0] = 8'sd2;  vb[0] = 8'sd3;
    va[1] = 8'sd4;  vb[1] = 8'sd5;
    va[2] = -8'sd1; vb[2] = 8'sd6;
    run_dot(3, -1, 0, -1, dcyc, res, ops, ens);
    check("basic_result", 32'(res), 32'h14);
    check("basic_done_cycle", 32'(dcyc), 32'd7);
    check("basic_opcodes", 32'(ops[17:0]), 32'h10410);
    check("basic_enables", 32'(ens), 32'd6);

    // Wrap: 100*2 = 200 -> -56; -56 + 50 = -6
    va[0] = 8'sd100; vb[0] = 8'sd2;
    va[1] = 8'sd50;  vb[1] = 8'sd1;
    run_dot(2, -1, 0, -1, dcyc, res, ops, ens);
    check("wrap_result", 32'(res), 32'hFA);
    check("wrap_done_cycle", 32'(dcyc), 32'd5);

    // Stall: three idle cycles before the second pair.
    va[0] = 8'sd2;  vb[0] = 8'sd3;
    va[1] = 8'sd4;  vb[1] = 8'sd5;
    va[2] = -8'sd1; vb[2] = 8'sd6;
    run_dot(3, 1, 3, -1, dcyc, res, ops, ens);
    check("stall_result", 32'(res), 32'h14);
    check("stall_done_cycle", 32'(dcyc), 32'd10);
    check("stall_enables", 32'(ens), 32'd6);

    // Zero length: done next cycle, result cleared, ALU never enabled.
    run_dot(0, -1, 0, -1, dcyc, res, ops, ens);
    check("zero_result", 32'(res), 32'd0);
    check("zero_done_cycle", 32'(dcyc), 32'd1);
    check("zero_enables", 32'(ens), 32'd0);

    // Start while busy must be ignored.
    run_dot(3, -1, 0, 3, dcyc, res, ops, ens);
    check("busy_start_result", 32'(res), 32'h14);
    check("busy_start_done_cycle", 32'(dcyc), 32'd7);

    // Async reset after the first ACC, with a valid pair pending in MUL.
    @(negedge clock_in);
    start_in  = 1'b1;
    length_in = 4'd3;
    a_in = 8'sd2; b_in = 8'sd3; operand_valid_in = 1'b1;
    @(posedge clock_in);      // accept -> MUL
    @(negedge clock_in);
    start_in = 1'b0;
    @(posedge clock_in);      // MUL -> ACC
    @(posedge clock_in);      // ACC -> MUL
    a_in = 8'sd4; b_in = 8'sd5;
    #1;
    check("pre_reset_enable", 32'(alu_enable_out), 32'd1);
    #1;
    reset_in = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy_out), 32'd0);
    check("async_rst_enable", 32'(alu_enable_out), 32'd0);
    check("async_rst_ready", 32'(operand_ready_out), 32'd0);
    check("async_rst_opcode", 32'(alu_opcode_out), 32'd0);
    check("async_rst_in1", 32'($unsigned(alu_input1_out)), 32'd0);
    check("async_rst_in2", 32'($unsigned(alu_input2_out)), 32'd0);
    check("async_rst_result", 32'($unsigned(result_out)), 32'd0);
    @(negedge clock_in);
    check("async_rst_no_done", 32'(done_out), 32'd0);
    reset_in = 1'b0;
    operand_valid_in = 1'b0;

    va[0] = -8'sd3; vb[0] = -8'sd4;
    run_dot(1, -1, 0, -1, dcyc, res, ops, ens);
    check("post_reset_result", 32'(res), 32'h0C);
    check("post_reset_done_cycle", 32'(dcyc), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
